md_unit_ctrl: RTL and testbench



---
 rtl/md_unit_ctrl_pkg.sv | 33 +++
 rtl/md_unit_ctrl.sv | 149 ++++++++++++++
 tb/tb_md_unit_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/md_unit_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: operation codes,
// the implied sequencer state and a classifier for multi-cycle operations.
package md_unit_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  // IDLE when the latency counter is zero, BUSY otherwise.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int CNT_W = 4;

  // True for operations that occupy the unit for several cycles.
  function automatic logic is_long_op(input logic [2:0] op);
    logic res;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer for the E stage. Holds HI/LO, computes the
// result at start, keeps it pending for the modelled latency, then commits.
// Also raises the stall request for a following MD-class instruction in D.
module md_unit_ctrl
  import md_unit_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  md_op,
  input  logic        md_start,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mf_sel,
  input  logic        d_is_md,
  output logic        busy,
  output logic [31:0] mf_data,
  output logic        md_stall
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [31:0]      hi_r, hi_s;
  logic [31:0]      lo_r, lo_s;
  logic [31:0]      pend_hi_r, pend_hi_s;
  logic [31:0]      pend_lo_r, pend_lo_s;
  logic             pend_ok_r, pend_ok_s;

  md_state_e        state_s;
  md_op_e           op_s;

  logic signed [63:0] sa_s, sb_s, sdiv_s, smul_s;
  logic        [63:0] ua_s, ub_s, udiv_s, umul_s;
  logic        [31:0] sq_s, sr_s, uq_s, ur_s;
  logic               div_zero_s;

  // Behavioural arithmetic on extended operands; a zero divisor is replaced
  // by one so the datapath never produces X (the result is discarded anyway).
  always_comb begin
    sa_s       = {{32{rs_val[31]}}, rs_val};
    sb_s       = {{32{rt_val[31]}}, rt_val};
    ua_s       = {32'd0, rs_val};
    ub_s       = {32'd0, rt_val};
    div_zero_s = (rt_val == 32'd0);
    if (div_zero_s) begin
      sdiv_s = 64'sd1;
      udiv_s = 64'd1;
    end else begin
      sdiv_s = sb_s;
      udiv_s = ub_s;
    end
    smul_s = sa_s * sb_s;
    umul_s = ua_s * ub_s;
    sq_s   = 32'(sa_s / sdiv_s);
    sr_s   = 32'(sa_s % sdiv_s);
    uq_s   = 32'(ua_s / udiv_s);
    ur_s   = 32'(ua_s % udiv_s);
  end

  // Next-state logic: accept a new operation in IDLE, count down and
  // commit the pending result on the 1->0 transition in BUSY.
  always_comb begin
    cnt_s     = cnt_r;
    hi_s      = hi_r;
    lo_s      = lo_r;
    pend_hi_s = pend_hi_r;
    pend_lo_s = pend_lo_r;
    pend_ok_s = pend_ok_r;
    op_s      = md_op_e'(md_op);
    state_s   = (cnt_r != {CNT_W{1'b0}}) ? ST_BUSY : ST_IDLE;
    case (state_s)
      ST_IDLE: begin
        if (md_start) begin
          case (op_s)
            MD_MULT: begin
              pend_hi_s = smul_s[63:32];
              pend_lo_s = smul_s[31:0];
              pend_ok_s = 1'b1;
              cnt_s     = MUL_CNT;
            end
            MD_MULTU: begin
              pend_hi_s = umul_s[63:32];
              pend_lo_s = umul_s[31:0];
              pend_ok_s = 1'b1;
              cnt_s     = MUL_CNT;
            end
            MD_DIV: begin
              pend_hi_s = sr_s;
              pend_lo_s = sq_s;
              pend_ok_s = ~div_zero_s;
              cnt_s     = DIV_CNT;
            end
            MD_DIVU: begin
              pend_hi_s = ur_s;
              pend_lo_s = uq_s;
              pend_ok_s = ~div_zero_s;
              cnt_s     = DIV_CNT;
            end
            MD_MTHI: hi_s = rs_val;
            MD_MTLO: lo_s = rs_val;
            default: cnt_s = cnt_r;
          endcase
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_BUSY: begin
        // A start while busy is deliberately ignored: nothing is reloaded.
        cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        if ((cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) && pend_ok_r) begin
          hi_s = pend_hi_r;
          lo_s = pend_lo_r;
        end else begin
          hi_s = hi_r;
          lo_s = lo_r;
        end
      end
      default: cnt_s = {CNT_W{1'b0}};
    endcase
  end

  // State registers; reset aborts any operation in flight and clears HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= {CNT_W{1'b0}};
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_ok_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_s;
      hi_r      <= hi_s;
      lo_r      <= lo_s;
      pend_hi_r <= pend_hi_s;
      pend_lo_r <= pend_lo_s;
      pend_ok_r <= pend_ok_s;
    end
  end

  assign busy     = (cnt_r != {CNT_W{1'b0}});
  assign mf_data  = mf_sel ? hi_r : lo_r;
  assign md_stall = d_is_md & (busy | (md_start & is_long_op(md_op)));

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed testbench for md_unit_ctrl with hand-computed HI/LO results.
module tb_md_unit_ctrl;
  import md_unit_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  md_op;
  logic        md_start;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mf_sel;
  logic        d_is_md;
  logic        busy;
  logic [31:0] mf_data;
  logic        md_stall;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_unit_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .rst_n(rst_n), .md_op(md_op), .md_start(md_start),
    .rs_val(rs_val), .rt_val(rt_val), .mf_sel(mf_sel), .d_is_md(d_is_md),
    .busy(busy), .mf_data(mf_data), .md_stall(md_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
    mf_sel = 1'b0;
    #1;
    chk({tag, "_lo"}, mf_data, el);
    mf_sel = 1'b1;
    #1;
    chk({tag, "_hi"}, mf_data, eh);
    mf_sel = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input int lat,
                        input logic [31:0] eh, input logic [31:0] el);
    md_op = op; md_start = 1'b1; rs_val = rs; rt_val = rt; d_is_md = 1'b1; mf_sel = 1'b0;
    #1;
    chk({tag, "_stall_start"}, {31'd0, md_stall}, 32'd1);
    tick();
    md_start = 1'b0; md_op = MD_NONE;
    #1;
    for (int i = 0; i < lat; i++) begin
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_stall_busy"}, {31'd0, md_stall}, 32'd1);
      chk({tag, "_mf_hold"}, mf_data, m_lo);
      tick();
    end
    chk({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
    chk({tag, "_stall_fall"}, {31'd0, md_stall}, 32'd0);
    read_hilo(tag, eh, el);
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic mt(input string tag, input logic [2:0] op, input logic [31:0] v);
    md_op = op; md_start = 1'b1; rs_val = v; d_is_md = 1'b0;
    tick();
    md_start = 1'b0; md_op = MD_NONE;
    #1;
    chk({tag, "_nobusy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; md_op = MD_NONE; md_start = 1'b0; rs_val = 32'd0; rt_val = 32'd0;
    mf_sel = 1'b0; d_is_md = 1'b1;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall_idle", {31'd0, md_stall}, 32'd0);
    read_hilo("rst", 32'd0, 32'd0);
    md_op = MD_MULT; md_start = 1'b1;
    #1;
    chk("rst_stall_start", {31'd0, md_stall}, 32'd1);
    md_start = 1'b0; md_op = MD_NONE;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Signed, unsigned and divide cases.
    run_op("mult", MD_MULT, 32'hFFFFFFFD, 32'd4, 5, 32'hFFFFFFFF, 32'hFFFFFFF4);
    run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
    run_op("div", MD_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_negd", MD_DIV, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu", MD_DIVU, 32'hFFFFFFF9, 32'd16, 10, 32'h00000009, 32'h0FFFFFFF);

    // Divide by zero leaves preloaded HI/LO untouched.
    mt("mthi", MD_MTHI, 32'h00000011);
    mt("mtlo", MD_MTLO, 32'h00000022);
    read_hilo("mt", 32'h00000011, 32'h00000022);
    m_hi = 32'h00000011; m_lo = 32'h00000022;
    run_op("divu0", MD_DIVU, 32'd1234, 32'd0, 10, 32'h00000011, 32'h00000022);

    // Start while busy is ignored and does not reload the counter.
    md_op = MD_MULT; md_start = 1'b1; rs_val = 32'd6; rt_val = 32'd7; d_is_md = 1'b1;
    tick();
    md_start = 1'b0; md_op = MD_NONE;
    #1;
    chk("ign_c1", {31'd0, busy}, 32'd1);
    tick();
    chk("ign_c2", {31'd0, busy}, 32'd1);
    tick();
    md_op = MD_MULT; md_start = 1'b1; rs_val = 32'd100; rt_val = 32'd100;
    #1;
    chk("ign_stall", {31'd0, md_stall}, 32'd1);
    tick();
    md_start = 1'b0; md_op = MD_NONE;
    #1;
    chk("ign_c4", {31'd0, busy}, 32'd1);
    tick();
    chk("ign_c5", {31'd0, busy}, 32'd1);
    tick();
    chk("ign_c6_fall", {31'd0, busy}, 32'd0);
    read_hilo("ign", 32'd0, 32'd42);

    // Reset in the middle of a divide aborts it.
    mt("mthi2", MD_MTHI, 32'h00000066);
    mt("mtlo2", MD_MTLO, 32'h00000055);
    read_hilo("pre_abort", 32'h00000066, 32'h00000055);
    md_op = MD_DIV; md_start = 1'b1; rs_val = 32'd100; rt_val = 32'd3; d_is_md = 1'b0;
    tick();
    md_start = 1'b0; md_op = MD_NONE;
    tick(); tick(); tick();
    chk("abort_busy4", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    read_hilo("abort", 32'd0, 32'd0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("abort_late_busy", {31'd0, busy}, 32'd0);
    read_hilo("abort_late", 32'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
